// File: rtl/riscv_pkg.sv
// Shared RV32I front-end types: PC-source encoding, IFU states and the fetch FIFO entry.
// Also holds the word-alignment helper used when loading a new fetch PC.
package riscv_pkg;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   typedef enum logic [1:0] {
      PCSRC_SEQ  = 2'b00,
      PCSRC_BR   = 2'b01,
      PCSRC_JALR = 2'b10
   } pcsrc_e;

   typedef enum logic {
      FETCH = 1'b0,
      DRAIN = 1'b1
   } ifu_state_e;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
   } fetch_entry_t;

   function automatic logic [31:0] word_align(input logic [31:0] a);
      return a & 32'hFFFF_FFFC;
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch entries for the IFU prefetch buffer.
// Flush empties the queue and takes priority over a same-cycle push.
module fetch_fifo
   import riscv_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic                     pop,
   input  logic                     flush,
   input  fetch_entry_t             wdata,
   output fetch_entry_t             head,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     empty
);

   localparam int AW = $clog2(DEPTH);

   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   fetch_entry_t  mem [DEPTH];

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         count <= count + (AW+1)'(push) - (AW+1)'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (push && !flush) mem[wr_ptr] <= wdata;
   end

   assign head  = mem[rd_ptr];
   assign empty = (count == '0);

endmodule

// File: rtl/ifu_prefetch.sv
// RV32I instruction-fetch stage: PC ownership, imem req/gnt/rvalid issue, prefetch FIFO, redirect drain.
// Define IFU_PERF_EN to add the saturating perf_redirects/perf_bubbles/perf_dropped counters.
module ifu_prefetch
   import riscv_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          FIFO_DEPTH = 4,
   parameter int          MAX_OUTST  = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [1:0]  PCSrcE,
   input  logic [31:0] PCTargetE,
   input  logic [31:0] ALUResultE,
   input  logic        StallD,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic [31:0] InstrD,
   output logic [31:0] PCD,
   output logic [31:0] PCPlus4D,
   output logic        ValidD
`ifdef IFU_PERF_EN
   ,
   output logic [31:0] perf_redirects,
   output logic [31:0] perf_bubbles,
   output logic [31:0] perf_dropped
`endif
);

   localparam int            CW        = $clog2(FIFO_DEPTH) + 1;
   localparam logic [CW:0]   DEPTH_LIM = (CW+1)'(FIFO_DEPTH);
   localparam logic [CW-1:0] OUTST_LIM = CW'(MAX_OUTST);

   ifu_state_e    state, state_nxt;
   logic          live;
   logic [31:0]   fetch_pc, fetch_pc_nxt;
   logic [31:0]   resp_pc, resp_pc_nxt;
   logic [31:0]   target;
   logic [CW-1:0] outst, outst_nxt;
   logic [CW-1:0] drop, drop_nxt;
   logic [CW-1:0] fifo_count;
   logic [CW:0]   in_use;
   logic          redirect, fire, resp, discard, push, pop, fifo_empty;
   fetch_entry_t  head, wentry;

   always_comb begin
      redirect = 1'b0;
      target   = fetch_pc;
      case (pcsrc_e'(PCSrcE))
         PCSRC_BR: begin
            redirect = 1'b1;
            target   = PCTargetE;
         end
         PCSRC_JALR: begin
            redirect = 1'b1;
            target   = ALUResultE & 32'hFFFF_FFFE;
         end
         default: ;
      endcase
   end

   // Issue credit covers both buffered and in-flight words, so a push never finds the FIFO full.
   assign in_use    = {1'b0, outst} + {1'b0, fifo_count};
   assign imem_req  = live && (state == FETCH) && (in_use < DEPTH_LIM) && (outst < OUTST_LIM);
   assign imem_addr = fetch_pc;

   assign fire      = imem_req && imem_gnt;
   // A response with nothing outstanding is a leftover from before reset and is ignored.
   assign resp      = imem_rvalid && (outst != '0);
   assign discard   = resp && (drop != '0);
   assign push      = resp && !discard && !redirect;
   assign pop       = ValidD && !StallD && !redirect;
   assign outst_nxt = outst + CW'(fire) - CW'(resp);
   assign wentry    = '{instr: imem_rdata, pc: resp_pc};

   always_comb begin
      state_nxt    = state;
      drop_nxt     = drop - CW'(discard);
      fetch_pc_nxt = fire ? fetch_pc + 32'd4 : fetch_pc;
      resp_pc_nxt  = push ? resp_pc + 32'd4 : resp_pc;
      if (redirect) begin
         // Everything still in flight after this edge belongs to the old path.
         drop_nxt     = outst_nxt;
         fetch_pc_nxt = word_align(target);
         resp_pc_nxt  = word_align(target);
         state_nxt    = (outst_nxt != '0) ? DRAIN : FETCH;
      end else if ((state == DRAIN) && (drop_nxt == '0)) begin
         state_nxt = FETCH;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= FETCH;
         live     <= 1'b0;
         fetch_pc <= RESET_PC;
         resp_pc  <= RESET_PC;
         outst    <= '0;
         drop     <= '0;
      end else begin
         state    <= state_nxt;
         live     <= 1'b1;
         fetch_pc <= fetch_pc_nxt;
         resp_pc  <= resp_pc_nxt;
         outst    <= outst_nxt;
         drop     <= drop_nxt;
      end
   end

   fetch_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .pop   (pop),
      .flush (redirect),
      .wdata (wentry),
      .head  (head),
      .count (fifo_count),
      .empty (fifo_empty)
   );

   assign ValidD   = !fifo_empty;
   assign InstrD   = ValidD ? head.instr : NOP_INSTR;
   assign PCD      = ValidD ? head.pc : 32'h0000_0000;
   assign PCPlus4D = PCD + 32'd4;

`ifdef IFU_PERF_EN
   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_redirects <= '0;
         perf_bubbles   <= '0;
         perf_dropped   <= '0;
      end else begin
         if (redirect)           perf_redirects <= sat_inc(perf_redirects);
         if (!ValidD && !StallD) perf_bubbles   <= sat_inc(perf_bubbles);
         if (resp && !push)      perf_dropped   <= sat_inc(perf_dropped);
      end
   end
`endif

endmodule

// File: tb/tb_ifu_prefetch.sv
// Directed bench for ifu_prefetch: cycle table for streaming/stall, then redirect and reset corner sequences.
module tb_ifu_prefetch;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        StallD;
   logic [1:0]  PCSrcE;
   logic [31:0] PCTargetE;
   logic [31:0] ALUResultE;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic [31:0] InstrD;
   logic [31:0] PCD;
   logic [31:0] PCPlus4D;
   logic        ValidD;
`ifdef IFU_PERF_EN
   logic [31:0] perf_redirects;
   logic [31:0] perf_bubbles;
   logic [31:0] perf_dropped;
`endif

   logic        hold;
   logic        m_rvalid;
   logic [31:0] m_rdata;
   logic        inj_rvalid;
   logic [31:0] q[$];

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   ifu_prefetch dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .PCSrcE      (PCSrcE),
      .PCTargetE   (PCTargetE),
      .ALUResultE  (ALUResultE),
      .StallD      (StallD),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_gnt    (imem_gnt),
      .imem_rvalid (imem_rvalid),
      .imem_rdata  (imem_rdata),
      .InstrD      (InstrD),
      .PCD         (PCD),
      .PCPlus4D    (PCPlus4D),
      .ValidD      (ValidD)
`ifdef IFU_PERF_EN
      ,
      .perf_redirects (perf_redirects),
      .perf_bubbles   (perf_bubbles),
      .perf_dropped   (perf_dropped)
`endif
   );

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'h5A00_0013;
   endfunction

   // In-order memory: a granted request returns one cycle later unless hold is set.
   assign imem_rvalid = m_rvalid | inj_rvalid;
   assign imem_rdata  = inj_rvalid ? 32'hDEAD_BEEF : m_rdata;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q.delete();
         m_rvalid <= 1'b0;
         m_rdata  <= 32'h0;
      end else begin
         if (m_rvalid) void'(q.pop_front());
         if (imem_req && imem_gnt) q.push_back(imem_addr);
         if (q.size() > 0 && !hold) begin
            m_rvalid <= 1'b1;
            m_rdata  <= mem_word(q[0]);
         end else begin
            m_rvalid <= 1'b0;
         end
      end
   end

   typedef struct {
      logic        stall;
      logic        valid;
      logic [31:0] pcd;
      logic        req;
      logic [31:0] addr;
   } vec_t;

   vec_t vec[23];

   function automatic vec_t mk(input logic s, input logic v, input logic [31:0] p,
                               input logic r, input logic [31:0] a);
      vec_t t;
      t.stall = s; t.valid = v; t.pcd = p; t.req = r; t.addr = a;
      return t;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset(input logic hold_v);
      rst_n      = 1'b0;
      StallD     = 1'b0;
      PCSrcE     = 2'b00;
      PCTargetE  = 32'h0;
      ALUResultE = 32'h0;
      imem_gnt   = 1'b1;
      hold       = hold_v;
      inj_rvalid = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
   endtask

   task automatic release_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic wait_valid(input int max, output logic ok, output int hits40);
      ok = 1'b0;
      hits40 = 0;
      for (int k = 0; k < max; k++) begin
         @(negedge clk);
         if (imem_req && imem_addr == 32'h40) hits40++;
         if (ValidD) begin
            ok = 1'b1;
            break;
         end
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic ok;
      int   h40;

      // cycle-by-cycle expectations from reset release: stream, 10-cycle stall, release
      vec[0]  = mk(0, 0, 32'd0,  0, 32'd0);
      vec[1]  = mk(0, 0, 32'd0,  1, 32'd0);
      vec[2]  = mk(0, 0, 32'd0,  1, 32'd4);
      vec[3]  = mk(0, 1, 32'd0,  1, 32'd8);
      vec[4]  = mk(0, 1, 32'd4,  1, 32'd12);
      vec[5]  = mk(0, 1, 32'd8,  1, 32'd16);
      vec[6]  = mk(0, 1, 32'd12, 1, 32'd20);
      vec[7]  = mk(1, 1, 32'd16, 1, 32'd24);
      vec[8]  = mk(1, 1, 32'd16, 1, 32'd28);
      for (int c = 9; c <= 16; c++) vec[c] = mk(1, 1, 32'd16, 0, 32'd32);
      vec[17] = mk(0, 1, 32'd16, 0, 32'd32);
      vec[18] = mk(0, 1, 32'd20, 1, 32'd32);
      vec[19] = mk(0, 1, 32'd24, 1, 32'd36);
      vec[20] = mk(0, 1, 32'd28, 1, 32'd40);
      vec[21] = mk(0, 1, 32'd32, 1, 32'd44);
      vec[22] = mk(0, 1, 32'd36, 1, 32'd48);

      apply_reset(1'b0);
      chk("rst_valid",  {31'h0, ValidD},   32'd0);
      chk("rst_instr",  InstrD,            32'h0000_0013);
      chk("rst_pcd",    PCD,               32'h0);
      chk("rst_pcp4",   PCPlus4D,          32'h4);
      chk("rst_req",    {31'h0, imem_req}, 32'd0);
      release_reset();

      for (int i = 0; i < 23; i++) begin
         StallD = vec[i].stall;
         @(negedge clk);
         chk($sformatf("row%0d_valid", i), {31'h0, ValidD},   {31'h0, vec[i].valid});
         chk($sformatf("row%0d_pcd", i),   PCD,               vec[i].valid ? vec[i].pcd : 32'h0);
         chk($sformatf("row%0d_pcp4", i),  PCPlus4D,          (vec[i].valid ? vec[i].pcd : 32'h0) + 32'd4);
         chk($sformatf("row%0d_instr", i), InstrD,            vec[i].valid ? mem_word(vec[i].pcd) : 32'h0000_0013);
         chk($sformatf("row%0d_req", i),   {31'h0, imem_req}, {31'h0, vec[i].req});
         chk($sformatf("row%0d_addr", i),  imem_addr,         vec[i].addr);
         step();
      end

      // jalr redirect with odd target while streaming
      PCSrcE     = 2'b10;
      ALUResultE = 32'h0000_0203;
      step();
      PCSrcE = 2'b00;
      @(negedge clk);
      chk("jalr_addr",  imem_addr,         32'h0000_0200);
      chk("jalr_req",   {31'h0, imem_req}, 32'd0);
      chk("jalr_valid", {31'h0, ValidD},   32'd0);
      step();
      wait_valid(30, ok, h40);
      chk("jalr_timeout", {31'h0, ok}, 32'd1);
      chk("jalr_pcd",     PCD,         32'h0000_0200);
      chk("jalr_instr",   InstrD,      mem_word(32'h200));

      // branch redirect with two fetches outstanding
      apply_reset(1'b1);
      release_reset();
      repeat (3) step();
      PCSrcE    = 2'b01;
      PCTargetE = 32'h0000_0100;
      hold      = 1'b0;
      @(negedge clk);
      chk("br_outst_cap", {31'h0, imem_req}, 32'd0);
      step();
      PCSrcE = 2'b00;
      @(negedge clk);
      chk("br_drain_req", {31'h0, imem_req}, 32'd0);
      chk("br_valid",     {31'h0, ValidD},   32'd0);
      step();
      wait_valid(30, ok, h40);
      chk("br_timeout", {31'h0, ok}, 32'd1);
      chk("br_pcd",     PCD,         32'h0000_0100);
      chk("br_instr",   InstrD,      mem_word(32'h100));
`ifdef IFU_PERF_EN
      chk("perf_dropped",   perf_dropped,   32'd2);
      chk("perf_redirects", perf_redirects, 32'd1);
`endif

      // second redirect while draining from the first
      apply_reset(1'b1);
      release_reset();
      repeat (3) step();
      PCSrcE    = 2'b01;
      PCTargetE = 32'h0000_0040;
      step();
      PCTargetE = 32'h0000_0080;
      hold      = 1'b0;
      @(negedge clk);
      chk("b2b_req", {31'h0, imem_req}, 32'd0);
      step();
      PCSrcE = 2'b00;
      wait_valid(40, ok, h40);
      chk("b2b_timeout", {31'h0, ok}, 32'd1);
      chk("b2b_pcd",     PCD,         32'h0000_0080);
      chk("b2b_no40req", h40,         32'd0);

      // reset asserted mid-drain with a response on the bus
      apply_reset(1'b1);
      release_reset();
      repeat (3) step();
      PCSrcE    = 2'b01;
      PCTargetE = 32'h0000_0100;
      hold      = 1'b0;
      step();
      PCSrcE = 2'b00;
      #2;
      rst_n = 1'b0;
      hold  = 1'b1;
      #1;
      chk("mid_rst_valid", {31'h0, ValidD},   32'd0);
      chk("mid_rst_req",   {31'h0, imem_req}, 32'd0);
      chk("mid_rst_addr",  imem_addr,         32'h0);
      chk("mid_rst_instr", InstrD,            32'h0000_0013);
      chk("mid_rst_pcp4",  PCPlus4D,          32'h4);
      repeat (2) @(posedge clk);
      #1;
      rst_n      = 1'b1;
      inj_rvalid = 1'b1;
      @(negedge clk);
      chk("late_req", {31'h0, imem_req}, 32'd0);
      step();
      inj_rvalid = 1'b0;
      hold       = 1'b0;
      @(negedge clk);
      chk("late_ignored", {31'h0, ValidD}, 32'd0);
      chk("late_addr",    imem_addr,       32'h0);
      step();
      wait_valid(30, ok, h40);
      chk("restart_timeout", {31'h0, ok}, 32'd1);
      chk("restart_pcd",     PCD,         32'h0);
      chk("restart_instr",   InstrD,      mem_word(32'h0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ifu_prefetch.md
Name: ifu_prefetch

Overview:
- Instruction-fetch stage of the 5-stage RV32I pipeline; directly upstream of the decode stage.
- Owns the fetch PC and issues word requests to instruction memory over a req/gnt + rvalid handshake.
- Buffers returned words in a small prefetch FIFO and presents InstrD/PCD/PCPlus4D/ValidD to the IF/ID boundary, where the decode controller consumes them.
- Redirects on PCSrcE from the execute-stage branch unit and discards stale in-flight fetches.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- FIFO_DEPTH, 4, prefetch entries; power of 2, ≥2.
- MAX_OUTST, 2, maximum accepted-but-unreturned imem requests; 1..FIFO_DEPTH.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- PCSrcE  in  2  00 sequential, 01 jump to PCTargetE (branch/jal), 10 jump to ALUResultE (jalr); 11 treated as 00.
- PCTargetE  in  32  branch/jal target.
- ALUResultE  in  32  jalr target; bit0 forced to 0.
- StallD  in  1  decode holds; no FIFO pop.
- imem_req  out  1  request valid.
- imem_addr  out  32  word address, bits[1:0]=00.
- imem_gnt  in  1  request accepted this cycle.
- imem_rvalid  in  1  response valid; responses in order.
- imem_rdata  in  32  instruction word.
- InstrD  out  32  FIFO head instruction; 32'h0000_0013 (nop) when !ValidD.
- PCD  out  32  PC of head.
- PCPlus4D  out  32  PCD+4.
- ValidD  out  1  head valid.

Behaviour:
- Reset (async, rst_n=0):
  - fetch_pc=RESET_PC; FIFO empty; outst=0; drop=0; state=FETCH.
  - imem_req=0; ValidD=0; InstrD=nop; PCD=0; PCPlus4D=4.
  - Reset mid-transaction discards everything; responses arriving after reset release are ignored while drop=0 and outst=0.
- Request:
  - imem_req=1 when state=FETCH and outst + fifo_count < FIFO_DEPTH and outst < MAX_OUTST.
  - This credit rule makes FIFO overflow impossible.
  - imem_req and imem_addr stay stable until imem_gnt.
  - On req&gnt: fetch_pc+=4 (wraps mod 2^32); outst+=1.
- Response:
  - On imem_rvalid: outst-=1.
  - If drop>0: drop-=1 and the word is discarded.
  - Otherwise push {rdata, pc}; pc comes from a resp_pc counter advanced on each accepted push.
- Decode side:
  - Head registered in FIFO; ValidD=!empty.
  - Pop when ValidD & !StallD.
  - Push and pop in the same cycle are both honoured.
  - An empty FIFO with rvalid does not bypass: minimum latency is rvalid → ValidD next cycle.
- Redirect (PCSrcE != 00), same cycle:
  - FIFO flushed; ValidD=0 next cycle regardless of StallD.
  - fetch_pc=resp_pc=target.
  - drop = outst minus any response consumed this cycle, plus 1 if req&gnt occur this cycle.
  - state=DRAIN if the new drop>0, else FETCH.
  - Redirect overrides push, pop and the PC increment.
  - A second redirect during DRAIN retargets and adds only to what is still outstanding.
- FSM:
  - FETCH: normal issue.
  - DRAIN: imem_req=0 until drop=0, then FETCH.
- PCSrcE=11 is treated as no redirect.

Optional Feature:
- IFU_PERF_EN. When defined, adds these outputs, each reset to 0 and saturating at all-ones:
  - perf_redirects (32): count of redirect cycles.
  - perf_bubbles (32): count of cycles with ValidD=0 && !StallD.
  - perf_dropped (32): count of discarded responses.
- When undefined: ports and logic absent; behaviour otherwise identical.

Decomposition:
- Shared package riscv_pkg holds:
  - NOP_INSTR=32'h0000_0013.
  - typedef pcsrc_e {PCSRC_SEQ=2'b00, PCSRC_BR=2'b01, PCSRC_JALR=2'b10}.
  - typedef ifu_state_e {FETCH, DRAIN}.
  - typedef fetch_entry_t {logic[31:0] instr; logic[31:0] pc;}.
- Sub-module fetch_fifo: parameterised sync FIFO of fetch_entry_t with push, pop, flush, count. Flush has priority over push.

Test Plan:
- Reset, zero-wait memory (gnt=1, rvalid one cycle later), StallD=0 → ValidD rises 3 cycles after rst_n release; PCD sequence 0,4,8,C…; InstrD matches memory.
- StallD=1 for 10 cycles → FIFO fills to 4; imem_req=0 once outst+count=4; release StallD → 4 entries pop in order, no loss or duplication.
- Redirect with outst=2 and PCSrcE=01, PCTargetE=32'h100 → next two rvalid words dropped; first ValidD has PCD=32'h100; perf_dropped=2 when IFU_PERF_EN is defined.
- PCSrcE=10, ALUResultE=32'h203 → imem_addr=32'h200.
- Back-to-back redirects to 32'h40 then 32'h80 during DRAIN → no instruction from 32'h40 is ever ValidD; first valid PCD=32'h80.
- rst_n asserted mid-DRAIN with rvalid pending → outputs reset immediately; after release, a late rvalid is ignored and fetch restarts at RESET_PC.
